fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/next_pc_calc.sv | 42 ++++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Sign-extended branch displacement in bytes (word offset << 2).
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the retiring instruction: register jump, absolute
// jump, PC-relative branch or fall-through, plus the redirect flag.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic [31:0] alu_result,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic [31:0] reg_target;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [1:0]  unused_alu_low;

    assign reg_target    = {alu_result[31:2], 2'b00};
    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
    assign branch_target = pc_plus4 + branch_offset(branch_imm);
    assign unused_alu_low = alu_result[1:0];

    // Jumps take priority over branches; JR/JALR is a jump with a register target.
    always_comb begin
        next_pc = pc_plus4;
        if (jump && jump_reg) begin
            next_pc = reg_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch) begin
            next_pc = branch_target;
        end
    end

    // A taken branch that lands on pc_plus4 keeps the prefetch useful.
    assign redirect = (next_pc != pc_plus4);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, the instruction register and a one-entry
// prefetch buffer, and talks to instruction memory over a req/ack handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    input  logic        stall_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        jump_reg_in,
    input  logic [31:0] alu_result_in,
    input  logic [15:0] branch_imm_in,
    input  logic [25:0] jump_index_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        instr_valid_out
);
    import fetch_pkg::*;

    fetch_state_t state, state_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  pc_reg, pc_n;
    logic [31:0]  instr_reg, instr_n;
    logic         valid, valid_n;
    logic [31:0]  pf_buf, pf_buf_n;
    logic         pf_valid, pf_valid_n;
    logic         outstanding, outstanding_n;
    logic [31:0]  addr_reg, addr_n;

    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         redirect;
    logic         ack_hit;
    logic         retire;

    assign pc_plus4 = pc_reg + PC_STEP;
    assign ack_hit  = imem_ack_in && outstanding;
    assign retire   = valid && !stall_in;

    next_pc_calc u_next_pc (
        .pc_plus4   (pc_plus4),
        .branch_imm (branch_imm_in),
        .jump_index (jump_index_in),
        .alu_result (alu_result_in),
        .branch     (branch_in),
        .jump       (jump_in),
        .jump_reg   (jump_reg_in),
        .next_pc    (next_pc),
        .redirect   (redirect)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            pc_reg      <= RESET_PC;
            instr_reg   <= NOP_INSTR;
            valid       <= 1'b0;
            pf_buf      <= NOP_INSTR;
            pf_valid    <= 1'b0;
            outstanding <= 1'b0;
            addr_reg    <= RESET_PC;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            pc_reg      <= pc_n;
            instr_reg   <= instr_n;
            valid       <= valid_n;
            pf_buf      <= pf_buf_n;
            pf_valid    <= pf_valid_n;
            outstanding <= outstanding_n;
            addr_reg    <= addr_n;
        end
    end

    // The request is registered, so a new fetch is issued on the same edge
    // that retires its predecessor; this is what makes straight-line code bubble-free.
    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        pc_n          = pc_reg;
        instr_n       = instr_reg;
        valid_n       = valid;
        pf_buf_n      = pf_buf;
        pf_valid_n    = pf_valid;
        outstanding_n = outstanding;
        addr_n        = addr_reg;

        if (ack_hit) begin
            outstanding_n = 1'b0;
        end

        case (state)
            FETCH: begin
                if (ack_hit) begin
                    instr_n       = imem_data_in;
                    pc_n          = fetch_pc;
                    valid_n       = 1'b1;
                    state_n       = EXEC;
                    outstanding_n = 1'b1;
                    addr_n        = fetch_pc + PC_STEP;
                end else if (!outstanding) begin
                    outstanding_n = 1'b1;
                    addr_n        = fetch_pc;
                end
            end

            EXEC: begin
                if (retire) begin
                    if (redirect) begin
                        pf_valid_n = 1'b0;
                        valid_n    = 1'b0;
                        fetch_pc_n = next_pc;
                        if (outstanding && !imem_ack_in) begin
                            state_n = DRAIN;
                        end else begin
                            state_n       = FETCH;
                            outstanding_n = 1'b1;
                            addr_n        = next_pc;
                        end
                    end else if (pf_valid || ack_hit) begin
                        instr_n       = pf_valid ? pf_buf : imem_data_in;
                        pc_n          = pc_plus4;
                        pf_valid_n    = 1'b0;
                        outstanding_n = 1'b1;
                        addr_n        = pc_plus4 + PC_STEP;
                    end else begin
                        // Sequential successor not here yet; FETCH keeps waiting on the same request.
                        valid_n    = 1'b0;
                        fetch_pc_n = pc_plus4;
                        state_n    = FETCH;
                    end
                end else if (ack_hit) begin
                    pf_buf_n   = imem_data_in;
                    pf_valid_n = 1'b1;
                end else if (!outstanding && !pf_valid) begin
                    outstanding_n = 1'b1;
                    addr_n        = pc_plus4;
                end
            end

            DRAIN: begin
                if (ack_hit) begin
                    state_n       = FETCH;
                    outstanding_n = 1'b1;
                    addr_n        = fetch_pc;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign imem_req_out    = outstanding;
    assign imem_addr_out   = addr_reg;
    assign instr_out       = valid ? instr_reg : NOP_INSTR;
    assign pc_out          = pc_reg;
    assign pc_plus4_out    = pc_plus4;
    assign instr_valid_out = valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable instruction memory
// and a scoreboard of the (pc, instr) pairs the stage should present in order.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in = 1'b0;
    logic [31:0] imem_data_in = 32'h0;
    logic        stall_in = 1'b0;
    logic        branch_in = 1'b0;
    logic        jump_in = 1'b0;
    logic        jump_reg_in = 1'b0;
    logic [31:0] alu_result_in = 32'h0;
    logic [15:0] branch_imm_in = 16'h0;
    logic [25:0] jump_index_in = 26'h0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        instr_valid_out;

    int   vectors = 0;
    int   miscompares = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    logic spurious_ack = 1'b0;
    exp_t exp_q[$];

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_ack_in     (imem_ack_in),
        .imem_data_in    (imem_data_in),
        .stall_in        (stall_in),
        .branch_in       (branch_in),
        .jump_in         (jump_in),
        .jump_reg_in     (jump_reg_in),
        .alu_result_in   (alu_result_in),
        .branch_imm_in   (branch_imm_in),
        .jump_index_in   (jump_index_in),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .pc_plus4_out    (pc_plus4_out),
        .instr_valid_out (instr_valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == RESET_PC) return 32'h2008_0005;
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: acks a request after ack_delay waiting cycles, data valid with the ack.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (imem_req_out && rst_n) begin
                if (wait_cnt >= ack_delay) begin
                    imem_ack_in  = 1'b1;
                    imem_data_in = memWord(imem_addr_out);
                    wait_cnt     = 0;
                end else begin
                    imem_ack_in  = 1'b0;
                    imem_data_in = 32'hDEAD_BEEF;
                    wait_cnt     = wait_cnt + 1;
                end
            end else begin
                imem_ack_in  = spurious_ack;
                imem_data_in = 32'hBAD0_BAD0;
                wait_cnt     = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] bench did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic branch, input logic jump,
                                 input logic jump_reg, input logic [31:0] alu,
                                 input logic [15:0] imm, input logic [25:0] index);
        stall_in      = stall;
        branch_in     = branch;
        jump_in       = jump;
        jump_reg_in   = jump_reg;
        alu_result_in = alu;
        branch_imm_in = imm;
        jump_index_in = index;
    endtask

    task automatic pushExp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = memWord(pc);
        exp_q.push_back(e);
    endtask

    // One clock; a newly presented instruction is popped and compared.
    task automatic stepCycle();
        logic fresh;
        exp_t e;
        fresh = !instr_valid_out || !stall_in;
        @(negedge clk);
        if (instr_valid_out && fresh) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_pc", pc_out, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_pc", pc_out, e.pc);
                checkOutput("sb_instr", instr_out, e.instr);
                checkOutput("sb_link", pc_plus4_out, e.pc + 32'd4);
            end
        end
    endtask

    task automatic waitValid(input string tag, input int budget);
        int n = 0;
        while (!instr_valid_out && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, instr_valid_out, 1'b1);
    endtask

    task automatic runTo(input logic [31:0] target, input int budget);
        int n = 0;
        while (!(instr_valid_out && pc_out == target) && n < budget) begin
            stepCycle();
            checkOutput("no_bubble", instr_valid_out, 1'b1);
            n++;
        end
        checkOutput("reach_pc", pc_out, target);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        ack_delay = 2;
        stepCycle();
        stepCycle();
        checkOutput("rst_req", imem_req_out, 1'b0);
        checkOutput("rst_valid", instr_valid_out, 1'b0);
        checkOutput("rst_instr", instr_out, NOP);
        checkOutput("rst_pc", pc_out, RESET_PC);
        checkOutput("rst_link", pc_plus4_out, RESET_PC + 32'd4);

        // First fetch with a two-cycle memory
        rst_n = 1'b1;
        pushExp(RESET_PC);
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            checkOutput("first_req", imem_req_out, 1'b1);
            checkOutput("first_addr", imem_addr_out, RESET_PC);
            stepCycle();
        end
        waitValid("first_valid", 5);

        // Stall with prefetch landing; spurious acks with req low must be ignored
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_pc", pc_out, RESET_PC);
            checkOutput("stall_instr", instr_out, 32'h2008_0005);
            if (i == 2) spurious_ack = 1'b1;
            if (i == 4) spurious_ack = 1'b0;
            stepCycle();
        end
        checkOutput("stall_no_req", imem_req_out, 1'b0);
        checkOutput("stall_valid", instr_valid_out, 1'b1);

        // Straight-line code with immediate acks
        ack_delay = 0;
        pushExp(32'h0040_0004);
        pushExp(32'h0040_0008);
        pushExp(32'h0040_000C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        runTo(32'h0040_000C, 6);

        // Park on 0x40000C so 0x400010 lands in the buffer, then slow memory down
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        ack_delay = 6;
        stepCycle();
        checkOutput("pf_landed_no_req", imem_req_out, 1'b0);
        pushExp(32'h0040_0010);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        stepCycle();
        checkOutput("beq_pc", pc_out, 32'h0040_0010);

        // Backward branch while prefetch of 0x400014 is outstanding
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 16'hFFFC, 26'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        checkOutput("drain_valid", instr_valid_out, 1'b0);
        checkOutput("drain_instr", instr_out, NOP);
        checkOutput("drain_req", imem_req_out, 1'b1);
        checkOutput("drain_addr", imem_addr_out, 32'h0040_0014);
        for (int n = 0; n < 20 && imem_addr_out != 32'h0040_0004; n++) begin
            stepCycle();
            checkOutput("drain_no_valid", instr_valid_out, 1'b0);
        end
        checkOutput("branch_target_addr", imem_addr_out, 32'h0040_0004);
        ack_delay = 0;
        pushExp(32'h0040_0004);
        waitValid("branch_valid", 6);

        // Run to 0x400020, then J
        for (logic [31:0] a = 32'h0040_0008; a <= 32'h0040_0020; a += 32'd4) pushExp(a);
        runTo(32'h0040_0020, 12);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 26'h010_0040);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        checkOutput("j_valid", instr_valid_out, 1'b0);
        checkOutput("j_addr", imem_addr_out, 32'h0040_0100);
        pushExp(32'h0040_0100);
        waitValid("j_target_valid", 6);

        // JR with a misaligned register value
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0203, 16'h0, 26'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        checkOutput("jr_addr", imem_addr_out, 32'h0040_0200);
        pushExp(32'h0040_0200);
        waitValid("jr_target_valid", 6);

        // Jump and branch together: jump wins
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 16'h0010, 26'h010_0090);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        checkOutput("jb_addr", imem_addr_out, 32'h0040_0240);
        pushExp(32'h0040_0240);
        waitValid("jb_target_valid", 6);

        // Taken branch with zero offset is not a flush
        pushExp(32'h0040_0244);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0000, 26'h0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        checkOutput("br0_valid", instr_valid_out, 1'b1);
        checkOutput("br0_pc", pc_out, 32'h0040_0244);
        checkOutput("sb_drained", exp_q.size(), 0);

        // Restart, then reset while a request for 0x400008 is pending
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        pushExp(RESET_PC);
        stepCycle();
        checkOutput("restart_addr", imem_addr_out, RESET_PC);
        waitValid("restart_valid", 6);
        stepCycle();
        ack_delay = 10;
        pushExp(32'h0040_0004);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        checkOutput("pending_req", imem_req_out, 1'b1);
        checkOutput("pending_addr", imem_addr_out, 32'h0040_0008);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_req", imem_req_out, 1'b0);
        checkOutput("async_valid", instr_valid_out, 1'b0);
        checkOutput("async_instr", instr_out, NOP);
        checkOutput("async_pc", pc_out, RESET_PC);
        checkOutput("async_link", pc_plus4_out, RESET_PC + 32'd4);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        checkOutput("post_rst_req", imem_req_out, 1'b1);
        checkOutput("post_rst_addr", imem_addr_out, RESET_PC);
        ack_delay = 0;
        pushExp(RESET_PC);
        waitValid("post_rst_valid", 6);
        checkOutput("sb_final", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
